// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Data has priority over fetch, bounded by a streak limit so fetch cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [WW-1:0] WAIT_INIT  = WW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [SW-1:0]     streak_r;
  logic [WW-1:0]     wcnt_r;
  logic              sel_d_r;
  logic              we_r;
  logic              if_gnt_s, d_gnt_s;
  logic              mem_en_r, mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              if_rvalid_r, d_rvalid_r;
  logic [DATA_W-1:0] if_rdata_r, d_rdata_r;
  logic              busy_r;

  // Grants are only issued from IDLE and never while reset is held.
  always_comb begin
    state_s  = state_r;
    if_gnt_s = 1'b0;
    d_gnt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rst) begin
          state_s = IDLE;
        end else if (bus.d_req && !(bus.if_req && (streak_r == STREAK_MAX))) begin
          d_gnt_s = 1'b1;
          state_s = CMD;
        end else if (bus.if_req) begin
          if_gnt_s = 1'b1;
          state_s  = CMD;
        end else begin
          state_s = IDLE;
        end
      end
      CMD:  state_s = WAIT;
      WAIT: begin
        if (wcnt_r == {WW{1'b0}}) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, command, streak and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      streak_r    <= {SW{1'b0}};
      wcnt_r      <= {WW{1'b0}};
      sel_d_r     <= 1'b0;
      we_r        <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      d_rdata_r   <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != IDLE);
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (d_gnt_s) begin
            sel_d_r     <= 1'b1;
            we_r        <= bus.d_we;
            mem_en_r    <= 1'b1;
            mem_we_r    <= bus.d_we;
            mem_addr_r  <= bus.d_addr;
            mem_wdata_r <= bus.d_wdata;
            // Streak only counts data wins that actually made fetch wait.
            if (!bus.if_req) begin
              streak_r <= {SW{1'b0}};
            end else if (streak_r != STREAK_MAX) begin
              streak_r <= streak_r + SW'(1);
            end else begin
              streak_r <= streak_r;
            end
          end else if (if_gnt_s) begin
            sel_d_r     <= 1'b0;
            we_r        <= 1'b0;
            mem_en_r    <= 1'b1;
            mem_addr_r  <= bus.if_addr;
            mem_wdata_r <= {DATA_W{1'b0}};
            streak_r    <= {SW{1'b0}};
          end else begin
            streak_r <= streak_r;
          end
        end
        CMD: wcnt_r <= WAIT_INIT;
        WAIT: begin
          if (wcnt_r == {WW{1'b0}}) begin
            if (sel_d_r) begin
              d_rvalid_r <= 1'b1;
              d_rdata_r  <= we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
            end else begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= bus.mem_rdata;
            end
          end else begin
            wcnt_r <= wcnt_r - WW'(1);
          end
        end
        default: wcnt_r <= {WW{1'b0}};
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_s;
  assign bus.d_gnt     = d_gnt_s;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rvalid  = d_rvalid_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.busy      = busy_r;

endmodule
